// File: rtl/clock_date_setter_if.sv
// Date-editor bus: front-panel button pulses and live date in, working date,
// overwrite strobe and display status out. The master side drives the buttons
// and the live calendar date; the slave side is the editor itself.
interface clock_date_setter_if;
    logic [24:0] date_cur;
    logic        edit_start;
    logic        btn_next;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_cancel;
    logic [24:0] date_set;
    logic        date_ow;
    logic        editing;
    logic [1:0]  field_sel;

    modport master (
        output date_cur, edit_start, btn_next, btn_inc, btn_dec, btn_cancel,
        input  date_set, date_ow, editing, field_sel
    );

    modport slave (
        input  date_cur, edit_start, btn_next, btn_inc, btn_dec, btn_cancel,
        output date_set, date_ow, editing, field_sel
    );
endinterface

// File: rtl/clock_date_setter.sv
// Front-panel date editor for the BCD calendar. Snapshots the live date,
// edits day/month/year with BCD wrap, clamps the day to the month length
// (leap years included) and then pulses the overwrite strobe for one cycle.
// Date word layout: {day[5:0], month[4:0], year[13:0]}, all BCD.
// Optional: define EDIT_TIMEOUT_EN to abandon an edit after TIMEOUT_CYCLES
// cycles without a button press.
module clock_date_setter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic               clk,
    input  logic               nrst,
    clock_date_setter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, DAY, MONTH, YEAR, CLAMP, WRITE} state_t;

    localparam logic [24:0] RESET_DATE = {6'h01, 5'h01, 14'h2000};

    state_t      state;
    logic [24:0] date_set;
    logic        date_ow;
    logic        editing;
    logic [1:0]  field_sel;
    logic [5:0]  clamp_max;

    assign bus.date_set  = date_set;
    assign bus.date_ow   = date_ow;
    assign bus.editing   = editing;
    assign bus.field_sel = field_sel;

    // Day field 01..31 with wrap in both directions.
    function automatic logic [5:0] day_step(input logic [5:0] d, input logic up);
        logic [5:0] r;
        if (up) begin
            if (d == 6'h31)            r = 6'h01;
            else if (d[3:0] == 4'h9)   r = {d[5:4] + 2'd1, 4'h0};
            else                       r = {d[5:4], d[3:0] + 4'd1};
        end else begin
            if (d == 6'h01)            r = 6'h31;
            else if (d[3:0] == 4'h0)   r = {d[5:4] - 2'd1, 4'h9};
            else                       r = {d[5:4], d[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Month field 01..12 with wrap in both directions.
    function automatic logic [4:0] month_step(input logic [4:0] m, input logic up);
        logic [4:0] r;
        if (up) begin
            if (m == 5'h12)            r = 5'h01;
            else if (m == 5'h09)       r = 5'h10;
            else                       r = {m[4], m[3:0] + 4'd1};
        end else begin
            if (m == 5'h01)            r = 5'h12;
            else if (m == 5'h10)       r = 5'h09;
            else                       r = {m[4], m[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Four-digit BCD ripple; the thousands digit only keeps its low two bits
    // in the 14-bit year field.
    function automatic logic [13:0] year_step(input logic [13:0] y, input logic up);
        logic [15:0] v;
        logic [3:0]  dig;
        logic        carry;
        v     = {2'b00, y};
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dig = v[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (dig == 4'h9) dig = 4'h0;
                    else begin dig = dig + 4'd1; carry = 1'b0; end
                end else begin
                    if (dig == 4'h0) dig = 4'h9;
                    else begin dig = dig - 4'd1; carry = 1'b0; end
                end
            end
            v[4*i +: 4] = dig;
        end
        return v[13:0];
    endfunction

    // Divisible-by-4 test on a two-digit BCD number.
    function automatic logic yy4(input logic [3:0] t, input logic [3:0] u);
        return (!t[0] && (u == 4'h0 || u == 4'h4 || u == 4'h8)) ||
               ( t[0] && (u == 4'h2 || u == 4'h6));
    endfunction

    // Century years are leap only when the century itself divides by 4.
    function automatic logic is_leap(input logic [13:0] y);
        if (y[7:0] != 8'h00) return yy4(y[7:4], y[3:0]);
        else                 return yy4({2'b00, y[13:12]}, y[11:8]);
    endfunction

    function automatic logic [5:0] max_day(input logic [4:0] m, input logic [13:0] y);
        logic [5:0] r;
        case (m)
            5'h04, 5'h06, 5'h09, 5'h11: r = 6'h30;
            5'h02:                      r = is_leap(y) ? 6'h29 : 6'h28;
            default:                    r = 6'h31;
        endcase
        return r;
    endfunction

    assign clamp_max = max_day(date_set[18:14], date_set[13:0]);

`ifdef EDIT_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        any_btn;
    assign any_btn = bus.btn_next | bus.btn_inc | bus.btn_dec | bus.btn_cancel;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Edit FSM: state, working date and all registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            date_set  <= RESET_DATE;
            date_ow   <= 1'b0;
            editing   <= 1'b0;
            field_sel <= 2'd0;
`ifdef EDIT_TIMEOUT_EN
            idle_cnt  <= 32'd0;
`endif
        end else begin
            date_ow <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.edit_start) begin
                        date_set  <= bus.date_cur;
                        state     <= DAY;
                        editing   <= 1'b1;
                        field_sel <= 2'd1;
`ifdef EDIT_TIMEOUT_EN
                        idle_cnt  <= 32'd0;
`endif
                    end
                end
                DAY, MONTH, YEAR: begin
                    if (bus.btn_cancel) begin
                        state     <= IDLE;
                        editing   <= 1'b0;
                        field_sel <= 2'd0;
                    end else if (bus.btn_next) begin
                        case (state)
                            DAY: begin
                                state     <= MONTH;
                                field_sel <= 2'd2;
                            end
                            MONTH: begin
                                state     <= YEAR;
                                field_sel <= 2'd3;
                            end
                            default: begin
                                state     <= CLAMP;
                                field_sel <= 2'd0;
                            end
                        endcase
                    end else if (bus.btn_inc != bus.btn_dec) begin
                        case (state)
                            DAY:     date_set[24:19] <= day_step(date_set[24:19], bus.btn_inc);
                            MONTH:   date_set[18:14] <= month_step(date_set[18:14], bus.btn_inc);
                            default: date_set[13:0]  <= year_step(date_set[13:0], bus.btn_inc);
                        endcase
                    end
`ifdef EDIT_TIMEOUT_EN
                    if (any_btn) begin
                        idle_cnt <= 32'd0;
                    end else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        idle_cnt  <= 32'd0;
                        state     <= IDLE;
                        editing   <= 1'b0;
                        field_sel <= 2'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
`endif
                end
                CLAMP: begin
                    if (date_set[24:19] > clamp_max) date_set[24:19] <= clamp_max;
                    state   <= WRITE;
                    editing <= 1'b0;
                    date_ow <= 1'b1;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    editing   <= 1'b0;
                    field_sel <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_date_setter.sv
// Self-checking bench for clock_date_setter: directed scenarios followed by
// random button traffic, all compared against a calendar-level reference
// model that works on plain integer day/month/year values.
// With EDIT_TIMEOUT_EN defined the timeout is exercised at 50 cycles.
module tb_clock_date_setter;

    localparam logic [31:0] TO = 32'd50;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    clock_date_setter_if bus();

    clock_date_setter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 day, 2 month, 3 year, 4 clamp, 5 write.
    int m_mode, m_day, m_month, m_year, m_idle;

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int fromBcd(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [24:0] packDate(input int d, input int m, input int y);
        logic [15:0] bd, bm, by;
        bd = toBcd(d);
        bm = toBcd(m);
        by = toBcd(y);
        return {bd[5:0], bm[4:0], by[13:0]};
    endfunction

    function automatic int yearStep(input int y, input logic up);
        int t;
        logic [15:0] b;
        t = up ? (y + 1) % 10000 : (y + 9999) % 10000;
        b = toBcd(t);
        return fromBcd({2'b00, b[13:0]});
    endfunction

    function automatic int maxDays(input int m, input int y);
        logic leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return leap ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [24:0] randDate();
        return packDate($urandom_range(1, 31), $urandom_range(1, 12), $urandom_range(0, 3999));
    endfunction

    task automatic modelReset();
        m_mode  = 0;
        m_day   = 1;
        m_month = 1;
        m_year  = 2000;
        m_idle  = 0;
    endtask

    task automatic modelStep(input logic [24:0] cur, input logic s, input logic n,
                             input logic i, input logic d, input logic c);
        case (m_mode)
            0: begin
                if (s) begin
                    m_day   = fromBcd({10'd0, cur[24:19]});
                    m_month = fromBcd({11'd0, cur[18:14]});
                    m_year  = fromBcd({2'b00, cur[13:0]});
                    m_mode  = 1;
                    m_idle  = 0;
                end
            end
            1, 2, 3: begin
                if (c) m_mode = 0;
                else if (n) m_mode = m_mode + 1;
                else if (i != d) begin
                    if (m_mode == 1)      m_day   = i ? m_day % 31 + 1 : (m_day + 29) % 31 + 1;
                    else if (m_mode == 2) m_month = i ? m_month % 12 + 1 : (m_month + 10) % 12 + 1;
                    else                  m_year  = yearStep(m_year, i);
                end
`ifdef EDIT_TIMEOUT_EN
                if (n || i || d || c) m_idle = 0;
                else if (m_idle == int'(TO) - 1) begin
                    m_idle = 0;
                    m_mode = 0;
                end else m_idle++;
`endif
            end
            4: begin
                if (m_day > maxDays(m_month, m_year)) m_day = maxDays(m_month, m_year);
                m_mode = 5;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [1:0] fs;
        fs = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
        checkOutput({tag, ".date_set"}, 32'(bus.date_set), 32'(packDate(m_day, m_month, m_year)));
        checkOutput({tag, ".date_ow"}, 32'(bus.date_ow), 32'(m_mode == 5));
        checkOutput({tag, ".editing"}, 32'(bus.editing), 32'(m_mode >= 1 && m_mode <= 4));
        checkOutput({tag, ".field_sel"}, 32'(bus.field_sel), 32'(fs));
    endtask

    task automatic applyStimulus(input logic [24:0] cur, input logic s, input logic n,
                                 input logic i, input logic d, input logic c, input string tag);
        @(negedge clk);
        bus.date_cur   = cur;
        bus.edit_start = s;
        bus.btn_next   = n;
        bus.btn_inc    = i;
        bus.btn_dec    = d;
        bus.btn_cancel = c;
        @(posedge clk);
        modelStep(cur, s, n, i, d, c);
        #1;
        bus.edit_start = 1'b0;
        bus.btn_next   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_dec    = 1'b0;
        bus.btn_cancel = 1'b0;
        checkModel(tag);
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic nextStep(input string tag);
        applyStimulus(bus.date_cur, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // Start an edit on cur, press next three times, then watch the commit.
    task automatic commitCheck(input logic [24:0] cur, input logic [24:0] exp, input string tag);
        applyStimulus(cur, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
        nextStep(tag);
        nextStep(tag);
        nextStep(tag);
        checkOutput({tag, ".clamp_ow"}, 32'(bus.date_ow), 32'd0);
        checkOutput({tag, ".clamp_editing"}, 32'(bus.editing), 32'd1);
        idleStep(tag);
        checkOutput({tag, ".write_ow"}, 32'(bus.date_ow), 32'd1);
        checkOutput({tag, ".write_date"}, 32'(bus.date_set), 32'(exp));
        idleStep(tag);
        checkOutput({tag, ".after_ow"}, 32'(bus.date_ow), 32'd0);
        checkOutput({tag, ".after_date"}, 32'(bus.date_set), 32'(exp));
    endtask

    initial begin
        logic s, n, i, d, c;
        bus.date_cur   = '0;
        bus.edit_start = 1'b0;
        bus.btn_next   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_dec    = 1'b0;
        bus.btn_cancel = 1'b0;
        modelReset();

        // Reset values.
        #12;
        checkOutput("reset.date_set", 32'(bus.date_set), 32'({6'h01, 5'h01, 14'h2000}));
        checkOutput("reset.date_ow", 32'(bus.date_ow), 32'd0);
        checkOutput("reset.editing", 32'(bus.editing), 32'd0);
        checkOutput("reset.field_sel", 32'(bus.field_sel), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        idleStep("idle");

        // Day wrap up and down.
        applyStimulus({6'h15, 5'h01, 14'h2020}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "daywrap");
        repeat (17) applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "daywrap");
        checkOutput("daywrap.up", 32'(bus.date_set[24:19]), 32'h01);
        checkOutput("daywrap.sel", 32'(bus.field_sel), 32'd1);
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "daywrap");
        checkOutput("daywrap.down", 32'(bus.date_set[24:19]), 32'h31);
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "daywrap");

        // Clamp 31 January -> 28 February 2021 on commit.
        applyStimulus({6'h31, 5'h01, 14'h2021}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "clamp");
        nextStep("clamp");
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "clamp");
        nextStep("clamp");
        nextStep("clamp");
        checkOutput("clamp.clamp_ow", 32'(bus.date_ow), 32'd0);
        idleStep("clamp");
        checkOutput("clamp.write_ow", 32'(bus.date_ow), 32'd1);
        checkOutput("clamp.date", 32'(bus.date_set), 32'({6'h28, 5'h02, 14'h2021}));
        idleStep("clamp");
        checkOutput("clamp.after_ow", 32'(bus.date_ow), 32'd0);

        // Leap years and 30-day months.
        commitCheck({6'h29, 5'h02, 14'h2000}, {6'h29, 5'h02, 14'h2000}, "leap2000");
        commitCheck({6'h29, 5'h02, 14'h1900}, {6'h28, 5'h02, 14'h1900}, "leap1900");
        commitCheck({6'h29, 5'h02, 14'h2024}, {6'h29, 5'h02, 14'h2024}, "leap2024");
        commitCheck({6'h29, 5'h02, 14'h2023}, {6'h28, 5'h02, 14'h2023}, "leap2023");
        commitCheck({6'h30, 5'h04, 14'h2023}, {6'h30, 5'h04, 14'h2023}, "apr30");
        commitCheck({6'h31, 5'h04, 14'h2023}, {6'h30, 5'h04, 14'h2023}, "apr31");

        // Year wrap 0000 -> 9999 (thousands digit kept to the 14-bit field), then cancel.
        applyStimulus({6'h01, 5'h01, 14'h0000}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "yearwrap");
        nextStep("yearwrap");
        nextStep("yearwrap");
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "yearwrap");
        checkOutput("yearwrap.year", 32'(bus.date_set[13:0]), 32'(14'(16'h9999)));
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "yearwrap");
        checkOutput("cancel.editing", 32'(bus.editing), 32'd0);
        checkOutput("cancel.sel", 32'(bus.field_sel), 32'd0);
        repeat (3) begin
            idleStep("cancel");
            checkOutput("cancel.ow", 32'(bus.date_ow), 32'd0);
        end

        // Simultaneous inputs and ignored edit_start.
        applyStimulus({6'h10, 5'h05, 14'h2010}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "simul");
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "simul");
        checkOutput("simul.incdec", 32'(bus.date_set[24:19]), 32'h10);
        applyStimulus({6'h20, 5'h06, 14'h2011}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "simul");
        checkOutput("simul.restart", 32'(bus.date_set), 32'({6'h10, 5'h05, 14'h2010}));
        checkOutput("simul.restart_sel", 32'(bus.field_sel), 32'd1);
        nextStep("simul");
        nextStep("simul");
        applyStimulus(bus.date_cur, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "simul");
        checkOutput("simul.cancelnext", 32'(bus.editing), 32'd0);
        repeat (3) begin
            idleStep("simul");
            checkOutput("simul.ow", 32'(bus.date_ow), 32'd0);
        end

`ifdef EDIT_TIMEOUT_EN
        // Edit abandoned after TO idle cycles in MONTH.
        applyStimulus({6'h05, 5'h07, 14'h1999}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "timeout");
        nextStep("timeout");
        repeat (int'(TO) - 1) idleStep("timeout");
        checkOutput("timeout.before", 32'(bus.editing), 32'd1);
        idleStep("timeout");
        checkOutput("timeout.after", 32'(bus.editing), 32'd0);
        checkOutput("timeout.ow", 32'(bus.date_ow), 32'd0);
`else
        // Without the timeout an edit persists while idle.
        applyStimulus({6'h05, 5'h07, 14'h1999}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "persist");
        nextStep("persist");
        repeat (60) idleStep("persist");
        checkOutput("persist.editing", 32'(bus.editing), 32'd1);
        checkOutput("persist.sel", 32'(bus.field_sel), 32'd2);
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "persist");
`endif

        // Asynchronous reset in the middle of an edit.
        applyStimulus({6'h12, 5'h11, 14'h3456}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "midreset");
        applyStimulus(bus.date_cur, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "midreset");
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset.date_set", 32'(bus.date_set), 32'({6'h01, 5'h01, 14'h2000}));
        checkOutput("midreset.editing", 32'(bus.editing), 32'd0);
        checkOutput("midreset.sel", 32'(bus.field_sel), 32'd0);
        checkOutput("midreset.ow", 32'(bus.date_ow), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        idleStep("midreset");

        // Random button traffic with a changing live date.
        for (int k = 0; k < 3000; k++) begin
            s = ($urandom_range(0, 99) < 10);
            n = ($urandom_range(0, 99) < 8);
            i = ($urandom_range(0, 99) < 25);
            d = ($urandom_range(0, 99) < 25);
            c = ($urandom_range(0, 99) < 2);
            applyStimulus(randDate(), s, n, i, d, c, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
